// File: rtl/acc_index_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_index_sequencer_pkg
//  Description : Shared definitions for the accumulator index sequencer:
//                the sequencer state encoding and the job mode constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_index_sequencer_pkg;

    // Sequencer states. The encoding is fixed at 2 bits.
    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_RUN   = 2'd1;
    localparam seq_state_t ST_FLUSH = 2'd2;
    localparam seq_state_t ST_DONE  = 2'd3;

    // Job modes. In ACCUM, columns are skewed one cycle per column so the
    // writes line up with the diagonal wavefront of the systolic array.
    // In DRAIN, all columns are read on the same cycle.
    localparam logic MODE_ACCUM = 1'b0;
    localparam logic MODE_DRAIN = 1'b1;

endpackage : acc_index_sequencer_pkg
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : skew_delay_line
//  Description : Fixed-depth shift register with synchronous clear. The top
//                level uses one instance per skewed column (depth m for
//                column m).
//  Ports       : clk     - clock, rising edge
//                i_clear - synchronous clear of every stage
//                i_data  - data entering the line
//                o_data  - data delayed by DEPTH cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1     // must be >= 1
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule : skew_delay_line
`default_nettype wire

// File: rtl/acc_index_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : acc_index_sequencer
//  Description : Generates per-column accumulator enables and row indices for
//                a systolic array. A job streams len row indices starting at
//                base_idx (wrapping modulo DEPTH) on column 0; in ACCUM mode
//                column m sees the same stream m cycles later, in DRAIN mode
//                all active columns see it at the same time.
//  Ports       : clk, reset   - clock / synchronous active-high reset
//                start, abort - job request / job cancel
//                mode, base_idx, len, num_cols - job configuration, captured
//                               when a start is accepted
//                busy, done   - job in progress / one-cycle completion pulse
//                enable_set   - per-column enable
//                idx_set      - per-column row index, IDX_WIDTH bits per column
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_index_sequencer
    import acc_index_sequencer_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ARRAY_M   = 8,
    parameter int IDX_WIDTH = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           mode,
    input  logic [IDX_WIDTH-1:0]           base_idx,
    input  logic [IDX_WIDTH:0]             len,
    input  logic [$clog2(ARRAY_M):0]       num_cols,
    output logic                           busy,
    output logic                           done,
    output logic [ARRAY_M-1:0]             enable_set,
    output logic [IDX_WIDTH*ARRAY_M-1:0]   idx_set
);

    localparam int c_CNT_W  = $clog2(ARRAY_M) + 1;
    localparam int c_LEN_W  = IDX_WIDTH + 1;
    localparam int c_LANE_W = IDX_WIDTH + 1;     // {enable, index}

    localparam logic [c_CNT_W-1:0] c_ARRAY_M = c_CNT_W'(ARRAY_M);

    // ------------------------------------------------------------------------
    // Registered job state
    // ------------------------------------------------------------------------
    seq_state_t             r_state;
    logic                   r_mode;
    logic [c_LEN_W-1:0]     r_len;
    logic [c_CNT_W-1:0]     r_ncols;      // already clamped to ARRAY_M
    logic [c_LEN_W-1:0]     r_k;          // lead counter
    logic [c_CNT_W-1:0]     r_flush;      // remaining flush cycles minus one
    logic                   r_busy;
    logic                   r_done;
    logic                   r_lead_en;    // column-0 stream, current cycle
    logic [IDX_WIDTH-1:0]   r_lead_idx;

    logic [c_CNT_W-1:0]     w_ncols_in_eff;
    logic                   w_last_lead;
    logic                   w_line_clear;
    logic [c_LANE_W-1:0]    w_lead;

    assign w_ncols_in_eff = (num_cols > c_ARRAY_M) ? c_ARRAY_M : num_cols;
    assign w_last_lead    = ((r_k + c_LEN_W'(1)) == r_len);
    assign w_lead         = {r_lead_en, r_lead_idx};

    // The skew lines are emptied when the job finishes so a later job with
    // more active columns never sees leftovers from a previous job.
    assign w_line_clear   = reset | abort | (r_state == ST_DONE);

    // ------------------------------------------------------------------------
    // Sequencer FSM. The column-0 stream registers are loaded with the value
    // for the next cycle, so the first index appears the cycle after start.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_ACCUM;
            r_len      <= '0;
            r_ncols    <= '0;
            r_k        <= '0;
            r_flush    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lead_en  <= 1'b0;
            r_lead_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mode  <= mode;
                        r_len   <= len;
                        r_ncols <= w_ncols_in_eff;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        if ((len == '0) || (w_ncols_in_eff == '0)) begin
                            // Empty job: report completion straight away.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_RUN;
                            r_lead_en  <= 1'b1;
                            r_lead_idx <= base_idx;
                        end
                    end
                end

                ST_RUN: begin
                    if (w_last_lead) begin
                        r_lead_en  <= 1'b0;
                        r_lead_idx <= '0;
                        // Skewed columns still need num_cols-1 cycles to drain.
                        if ((r_mode == MODE_ACCUM) && (r_ncols > c_CNT_W'(1))) begin
                            r_state <= ST_FLUSH;
                            r_flush <= r_ncols - c_CNT_W'(2);
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_k        <= r_k + c_LEN_W'(1);
                        r_lead_idx <= r_lead_idx + IDX_WIDTH'(1);  // wraps mod DEPTH
                    end
                end

                ST_FLUSH: begin
                    if (r_flush == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_flush <= r_flush - c_CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

    // ------------------------------------------------------------------------
    // Per-column lanes. Column 0 is the lead stream itself; column m taps a
    // delay line of depth m. DRAIN bypasses the delay so all columns align.
    // Only registers feed this selection and masking.
    // ------------------------------------------------------------------------
    for (genvar m = 0; m < ARRAY_M; m++) begin : g_col
        logic [c_LANE_W-1:0] w_delayed;
        logic [c_LANE_W-1:0] w_lane;
        logic                w_active;
        logic                w_en;

        if (m == 0) begin : g_direct
            assign w_delayed = w_lead;
        end else begin : g_skew
            skew_delay_line #(
                .WIDTH (c_LANE_W),
                .DEPTH (m)
            ) u_skew (
                .clk     (clk),
                .i_clear (w_line_clear),
                .i_data  (w_lead),
                .o_data  (w_delayed)
            );
        end

        assign w_lane        = (r_mode == MODE_DRAIN) ? w_lead : w_delayed;
        assign w_active      = (c_CNT_W'(m) < r_ncols);
        assign w_en          = w_active & w_lane[IDX_WIDTH];
        assign enable_set[m] = w_en;
        assign idx_set[IDX_WIDTH*m +: IDX_WIDTH] = w_en ? w_lane[IDX_WIDTH-1:0] : '0;
    end

endmodule : acc_index_sequencer
`default_nettype wire

// File: tb/tb_acc_index_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_index_sequencer
//  Description : Scoreboard bench for acc_index_sequencer. The driver applies
//                directed and random stimulus, updates a job-level reference
//                model and queues the expected outputs for the next cycle; a
//                monitor pops and compares each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_index_sequencer;
    import acc_index_sequencer_pkg::*;

    localparam int DEPTH   = 16;
    localparam int ARRAY_M = 8;
    localparam int IW      = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic                  mode = 1'b0;
    logic [IW-1:0]         base_idx = '0;
    logic [IW:0]           len = '0;
    logic [3:0]            num_cols = '0;
    logic                  busy;
    logic                  done;
    logic [ARRAY_M-1:0]    enable_set;
    logic [IW*ARRAY_M-1:0] idx_set;

    acc_index_sequencer #(
        .DEPTH     (DEPTH),
        .ARRAY_M   (ARRAY_M),
        .IDX_WIDTH (IW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .base_idx   (base_idx),
        .len        (len),
        .num_cols   (num_cols),
        .busy       (busy),
        .done       (done),
        .enable_set (enable_set),
        .idx_set    (idx_set)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Reference model: one job described by its start cycle and captured
    // configuration; outputs follow from arithmetic on the cycle number.
    // ------------------------------------------------------------------------
    typedef struct {
        bit act;
        int t;
        int len;
        int nc;
        bit mode;
        int base;
    } job_t;

    typedef struct {
        int                    c;
        logic                  busy;
        logic                  done;
        logic [ARRAY_M-1:0]    en;
        logic [IW*ARRAY_M-1:0] idx;
    } exp_t;

    job_t job = '{act: 1'b0, t: 0, len: 0, nc: 0, mode: 1'b0, base: 0};
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int job_end(job_t j);
        if (j.len == 0 || j.nc == 0) return j.t + 1;
        return j.t + 1 + j.len + ((j.mode == MODE_ACCUM) ? j.nc - 1 : 0);
    endfunction

    function automatic bit busy_at(job_t j, int c);
        return j.act && (c > j.t) && (c <= job_end(j));
    endfunction

    function automatic exp_t expect_at(job_t j, int c);
        exp_t e;
        e.c = c; e.busy = 1'b0; e.done = 1'b0; e.en = '0; e.idx = '0;
        if (busy_at(j, c)) begin
            e.busy = 1'b1;
            e.done = (c == job_end(j));
            for (int m = 0; m < j.nc; m++) begin
                int d;
                int k;
                d = (j.mode == MODE_ACCUM) ? m : 0;
                k = c - j.t - 1 - d;
                if (k >= 0 && k < j.len) begin
                    e.en[m] = 1'b1;
                    e.idx[IW*m +: IW] = IW'((j.base + k) % DEPTH);
                end
            end
        end
        return e;
    endfunction

    // One cycle of stimulus: inputs are applied for cycle cyc, the model is
    // advanced and the outputs expected in cycle cyc+1 are queued.
    task automatic drive(input bit rs, input bit st, input bit ab, input bit md,
                         input int b, input int l, input int n);
        int c;
        @(negedge clk);
        c = cyc;
        reset = rs; start = st; abort = ab; mode = md;
        base_idx = IW'(b); len = (IW+1)'(l); num_cols = 4'(n);
        if (rs || ab) begin
            job.act = 1'b0;
        end else if (st && !busy_at(job, c)) begin
            job = '{act: 1'b1, t: c, len: l, nc: (n > ARRAY_M) ? ARRAY_M : n,
                    mode: md, base: b};
        end
        sb.push_back(expect_at(job, c + 1));
    endtask

    // Idle cycles with the configuration inputs scrambled; a running job must
    // keep using the values captured at its start.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'($urandom), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 16)), int'($urandom_range(0, 15)));
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks += 4;
                if (busy !== e.busy) begin
                    n_errors++;
                    $display("FAIL busy cyc=%0d got=%b exp=%b", e.c, busy, e.busy);
                end
                if (done !== e.done) begin
                    n_errors++;
                    $display("FAIL done cyc=%0d got=%b exp=%b", e.c, done, e.done);
                end
                if (enable_set !== e.en) begin
                    n_errors++;
                    $display("FAIL enable_set cyc=%0d got=%b exp=%b", e.c, enable_set, e.en);
                end
                if (idx_set !== e.idx) begin
                    n_errors++;
                    $display("FAIL idx_set cyc=%0d got=%h exp=%h", e.c, idx_set, e.idx);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        // reset: rs, st, ab, md, base, len, ncols
        drive(1, 1, 0, 0, 3, 5, 4);
        drive(1, 0, 1, 0, 0, 0, 0);
        idle(2);

        // ACCUM base 0 len 4 on 3 columns
        drive(0, 1, 0, MODE_ACCUM, 0, 4, 3);
        idle(9);

        // DRAIN with index wrap 14,15,0,1
        drive(0, 1, 0, MODE_DRAIN, 14, 4, 8);
        idle(6);

        // empty jobs: len 0, then zero columns
        drive(0, 1, 0, MODE_ACCUM, 5, 0, 8);
        idle(3);
        drive(0, 1, 0, MODE_ACCUM, 5, 6, 0);
        idle(3);

        // abort mid-job, new start right after the abort
        drive(0, 1, 0, MODE_ACCUM, 2, 16, 8);
        idle(4);
        drive(0, 0, 1, MODE_ACCUM, 0, 0, 0);
        drive(0, 1, 0, MODE_DRAIN, 9, 3, 5);
        idle(6);

        // start + abort together in IDLE stays idle
        drive(0, 1, 1, MODE_ACCUM, 1, 4, 4);
        idle(2);

        // num_cols above ARRAY_M clamps, stray start during job ignored
        drive(0, 1, 0, MODE_ACCUM, 7, 5, 12);
        idle(1);
        drive(0, 1, 0, MODE_DRAIN, 0, 2, 1);
        idle(16);

        // reset mid-job
        drive(0, 1, 0, MODE_ACCUM, 0, 8, 6);
        idle(2);
        drive(1, 1, 0, MODE_ACCUM, 0, 8, 6);
        idle(3);

        // back-to-back: start on DONE cycle ignored, next cycle accepted
        drive(0, 1, 0, MODE_DRAIN, 4, 2, 2);
        idle(2);
        drive(0, 1, 0, MODE_ACCUM, 8, 3, 3);
        drive(0, 1, 0, MODE_ACCUM, 15, 3, 3);
        idle(10);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 49) == 0),
                  1'($urandom),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 16)),
                  int'($urandom_range(0, 15)));
        end
        idle(20);

        @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_acc_index_sequencer
`default_nettype wire

// File: doc/acc_index_sequencer.md
ACC_INDEX_SEQUENCER -- requirements
Module: acc_index_sequencer

Interface
REQ-001 Parameter DEPTH, 16, accumulator rows per column (power of two, >=2).
REQ-002 Parameter ARRAY_M, 8, systolic array columns (>=1).
REQ-003 Parameter IDX_WIDTH, $clog2(DEPTH), row index width.
REQ-004 Port clk  input  1  clock; all logic rising-edge.
REQ-005 Port reset  input  1  reset, synchronous, active-high.
REQ-006 Port start  input  1  one-cycle request; sampled only in IDLE.
REQ-007 Port abort  input  1  cancel current job.
REQ-008 Port mode  input  1  0 = ACCUM (skewed), 1 = DRAIN (aligned); captured at start.
REQ-009 Port base_idx  input  IDX_WIDTH  first row index; captured at start.
REQ-010 Port len  input  IDX_WIDTH+1  rows per column, 0..DEPTH; captured at start.
REQ-011 Port num_cols  input  $clog2(ARRAY_M)+1  active columns; captured at start.
REQ-012 Port busy  output  1  job in progress.
REQ-013 Port done  output  1  one-cycle job-complete pulse.
REQ-014 Port enable_set  output  ARRAY_M  per-column write/read enable.
REQ-015 Port idx_set  output  IDX_WIDTH*ARRAY_M  per-column row index, column m at bits [IDX_WIDTH*m +: IDX_WIDTH].

Function
REQ-016 FSM states IDLE, RUN, FLUSH, DONE; IDLE on reset.
REQ-017 IDLE->RUN when start=1 and abort=0; config registered same edge (start at cycle T).
REQ-018 RUN: lead counter k=0..len-1 at cycles T+1..T+len; column-0 stream = enable 1, idx (base_idx+k) mod DEPTH (wrap, no carry out).
REQ-019 ACCUM: column m output equals column-0 stream delayed m cycles; DRAIN: all columns equal column-0 stream, zero delay.
REQ-020 Columns m >= num_cols_eff: enable 0, idx 0 always; num_cols_eff = min(num_cols, ARRAY_M).
REQ-021 Any column with enable 0 drives idx 0.
REQ-022 RUN->FLUSH after last lead cycle; FLUSH lasts tail = (ACCUM ? num_cols_eff-1 : 0) cycles (0 cycles = pass through).
REQ-023 DONE lasts one cycle at T+1+len+tail, done=1, all enables 0, then IDLE.
REQ-024 busy=1 from T+1 through DONE cycle inclusive; 0 in IDLE.
REQ-025 len=0 or num_cols_eff=0: no enable ever asserted; DONE at T+1, then IDLE.
REQ-026 start while busy ignored, no queueing; start and done in same cycle ignored.
REQ-027 abort=1 in any state: next cycle IDLE, enable_set/idx_set 0, pipelines cleared, done not pulsed; abort with start in IDLE -> stay IDLE.
REQ-028 Input changes of mode/base_idx/len/num_cols after capture have no effect on the running job.
REQ-029 Back-to-back: start at the cycle after DONE accepted normally.

Reset
REQ-030 reset dominates abort/start; state IDLE, busy 0, done 0, enable_set 0, idx_set 0, counters and delay stages 0, next cycle.
REQ-031 reset mid-job: same values as REQ-030, no done pulse.

Structure
REQ-032 Shared package holds state encoding and MODE_ACCUM/MODE_DRAIN constants.
REQ-033 One sub-module skew_delay_line (parametrised width, depth, sync clear) supplies the per-column delay; column m instance depth m, bypassed in DRAIN.
REQ-034 All outputs registered; no combinational path input->output.

Verification
REQ-035 ACCUM, base 0, len 4, num_cols 3, start at T -> col0 en T+1..T+4 idx 0,1,2,3; col2 en T+3..T+6; cols 3..7 en 0; done at T+7.
REQ-036 DRAIN, base 14, len 4, num_cols 8 -> all cols en T+1..T+4 idx 14,15,0,1; done at T+5.
REQ-037 len 0, num_cols 8 -> no enables, busy at T+1 only, done at T+1.
REQ-038 ACCUM len 16 num_cols 8, abort at T+5 -> enable_set 0 from T+6, no done, new start at T+6 accepted.
REQ-039 Start pulse at T+2 during job -> ignored; num_cols 12 (ARRAY_M 8) -> clamped to 8, tail 7.
REQ-040 reset at T+3 mid-job -> all outputs 0 at T+4, busy 0, no done.
